// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage of the multi-cycle CPU. Holds the program counter,
//   presents it as the byte address to the (combinational, big-endian) instruction
//   memory, and latches the returned word into the instruction register when the
//   control unit asks for it. Computes the next PC (sequential, branch, register
//   jump, absolute jump), keeps a sticky halt flag and counts IR loads.
//
// Parameters
//   RESET_PC  PC value loaded on reset (bits [1:0] must be zero)
//   HALT_OP   opcode (IR[31:26]) that stops further fetch
//
// Ports
//   CLK       in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   PCWre     in   PC write enable
//   IRWre     in   IR write enable
//   PCSrc     in   next-PC select: 00 PC+4, 01 branch, 10 RegData, 11 jump
//   Imm       in   sign-extended immediate (branch offset in words)
//   RegData   in   rs read data, jr target
//   IDataIn   in   instruction word from instruction memory
//   IAddr     out  byte address to instruction memory (== PC)
//   PC        out  current program counter
//   PC4       out  PC + 4 (jal link value)
//   IR        out  instruction register
//   Halted    out  sticky halt flag, cleared only by Reset
//   FetchCnt  out  number of IR loads since reset (wraps)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Imm,
  input  logic [31:0] RegData,
  input  logic [31:0] IDataIn,
  output logic [31:0] IAddr,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] IR,
  output logic        Halted,
  output logic [31:0] FetchCnt
);

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_BRANCH = 2'b01,
    SRC_JR     = 2'b10,
    SRC_JUMP   = 2'b11
  } pcsrc_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  fetch_state_e state;
  pcsrc_e       sel;

  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] cnt_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] next_raw;
  logic [31:0] next_pc;
  logic        ir_load;
  logic        pc_load;
  logic        halt_word;

  assign sel = pcsrc_e'(PCSrc);

  // All arithmetic is modulo 2^32; the shift drops Imm[31:30].
  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = Imm << 2;

  always_comb begin
    next_raw = pc_plus4;
    unique case (sel)
      SRC_SEQ:    next_raw = pc_plus4;
      SRC_BRANCH: next_raw = pc_plus4 + br_offset;
      SRC_JR:     next_raw = RegData;
      SRC_JUMP:   next_raw = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      default:    next_raw = pc_plus4;
    endcase
  end

  // Every PC load is word aligned; an unaligned jr target is silently truncated.
  assign next_pc = {next_raw[31:2], 2'b00};

  // Enables are ignored once halted; the halt-word load itself still completes
  // together with any PC update on that same edge.
  assign ir_load   = IRWre && (state == ST_RUN);
  assign pc_load   = PCWre && (state == ST_RUN);
  assign halt_word = (IDataIn[31:26] == HALT_OP);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      cnt_q <= '0;
      state <= ST_RUN;
    end else begin
      if (ir_load) begin
        ir_q  <= IDataIn;
        cnt_q <= cnt_q + 32'd1;
        if (halt_word) begin
          state <= ST_HALT;
        end
      end
      if (pc_load) begin
        pc_q <= next_pc;
      end
    end
  end

  assign PC       = pc_q;
  assign IAddr    = pc_q;
  assign PC4      = pc_plus4;
  assign IR       = ir_q;
  assign FetchCnt = cnt_q;
  assign Halted   = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model (plain arithmetic on
//   PC/IR/halt/count variables) is stepped alongside the DUT; directed sequences
//   cover the listed scenarios and a randomized phase exercises all PCSrc modes.

module tb_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        PCWre;
  logic        IRWre;
  logic [1:0]  PCSrc;
  logic [31:0] Imm;
  logic [31:0] RegData;
  logic [31:0] IDataIn;
  logic [31:0] IAddr;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] IR;
  logic        Halted;
  logic [31:0] FetchCnt;

  // instruction memory override (for injecting specific words such as halt/jump)
  logic        ovr_en;
  logic [31:0] ovr_word;

  int unsigned checks;
  int unsigned errors;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_halt;
  logic [31:0] m_cnt;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .HALT_OP (6'b111111)
  ) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .PCWre   (PCWre),
    .IRWre   (IRWre),
    .PCSrc   (PCSrc),
    .Imm     (Imm),
    .RegData (RegData),
    .IDataIn (IDataIn),
    .IAddr   (IAddr),
    .PC      (PC),
    .PC4     (PC4),
    .IR      (IR),
    .Halted  (Halted),
    .FetchCnt(FetchCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: word0 fixed, everything else a hash with bit 31 clear so the
  // halt opcode never appears unless injected.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0221_1820;
    return (a * 32'h9E37_79B1) & 32'h7FFF_FFFF;
  endfunction

  assign IDataIn = ovr_en ? ovr_word : mem(IAddr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},     PC,       m_pc);
    check({tag, ".iaddr"},  IAddr,    m_pc);
    check({tag, ".pc4"},    PC4,      m_pc + 32'd4);
    check({tag, ".ir"},     IR,       m_ir);
    check({tag, ".halted"}, {31'd0, Halted}, {31'd0, m_halt});
    check({tag, ".cnt"},    FetchCnt, m_cnt);
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_ir   = 32'h0;
    m_halt = 1'b0;
    m_cnt  = 32'h0;
  endtask

  // One clock cycle: drive inputs, step model, sample 1 time unit after the edge.
  task automatic cycle(input string tag, input logic pw, input logic iw,
                       input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] rd, input logic oe, input logic [31:0] ow);
    logic [31:0] seq;
    logic [31:0] tgt;
    logic [31:0] word;
    PCWre    = pw;
    IRWre    = iw;
    PCSrc    = src;
    Imm      = imm;
    RegData  = rd;
    ovr_en   = oe;
    ovr_word = ow;
    seq = m_pc + 32'd4;
    case (src)
      2'd0:    tgt = seq;
      2'd1:    tgt = seq + imm * 32'd4;
      2'd2:    tgt = rd;
      default: tgt = (seq & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
    endcase
    tgt  = tgt & ~32'd3;
    word = oe ? ow : mem(m_pc);
    @(posedge CLK);
    if (!m_halt) begin
      if (iw) begin
        m_ir  = word;
        m_cnt = m_cnt + 32'd1;
        if (word[31:26] == 6'b111111) m_halt = 1'b1;
      end
      if (pw) m_pc = tgt;
    end
    #1;
    check_all(tag);
  endtask

  task automatic jr_to(input logic [31:0] a);
    cycle("jr", 1'b1, 1'b0, 2'd2, 32'h0, a, 1'b0, 32'h0);
  endtask

  task automatic random_cycles(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      logic [31:0] r;
      r = $urandom;
      cycle(tag, r[0], r[1], r[3:2], {{16{r[31]}}, r[31:16]}, $urandom, 1'b0, 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    PCWre    = 1'b0;
    IRWre    = 1'b0;
    PCSrc    = 2'd0;
    Imm      = '0;
    RegData  = '0;
    ovr_en   = 1'b0;
    ovr_word = '0;
    Reset    = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    Reset = 1'b0;

    // sequential fetch
    cycle("ifetch", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("ir_word0", IR, 32'h0221_1820);
    cycle("seq", 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("seq_pc", PC, 32'h4);
    check("seq_pc4", PC4, 32'h8);
    check("seq_cnt", FetchCnt, 32'h1);

    // branch backward then forward
    jr_to(32'h10);
    cycle("br_neg", 1'b1, 1'b0, 2'd1, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'h0);
    check("br_neg_pc", PC, 32'h0C);
    cycle("br_pos", 1'b1, 1'b0, 2'd1, 32'h3, 32'h0, 1'b0, 32'h0);
    check("br_pos_pc", PC, 32'h1C);

    // absolute jump then unaligned jr
    jr_to(32'h8000_0010);
    cycle("ld_j", 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0800_0040);
    cycle("jump", 1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 1'b0, 32'h0);
    check("jump_pc", PC, 32'h8000_0100);
    jr_to(32'h0000_0207);
    check("jr_pc", PC, 32'h0000_0204);

    // wrap-around
    jr_to(32'hFFFF_FFFC);
    cycle("wrap", 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("wrap_pc", PC, 32'h0);
    check("wrap_pc4", PC4, 32'h4);

    random_cycles("rand", 400);

    // halt with simultaneous PC update
    jr_to(32'h20);
    cycle("halt", 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 32'hFC00_0000);
    check("halt_flag", {31'd0, Halted}, 32'h1);
    check("halt_ir", IR, 32'hFC00_0000);
    check("halt_pc", PC, 32'h24);
    for (int unsigned i = 0; i < 10; i++) begin
      cycle("frozen", 1'b1, 1'b1, i[1:0], $urandom, $urandom, 1'b0, 32'h0);
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("halt_rst");
    @(negedge CLK);
    Reset = 1'b0;

    // asynchronous reset between edges while halted at 0x40
    jr_to(32'h3C);
    cycle("halt2", 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 32'hFC00_1234);
    check("halt2_pc", PC, 32'h40);
    check("halt2_flag", {31'd0, Halted}, 32'h1);
    @(negedge CLK);
    #2;
    PCWre = 1'b1;
    IRWre = 1'b1;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge CLK);
    #1;
    check_all("rst_hold");
    @(negedge CLK);
    Reset = 1'b0;

    random_cycles("post", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
